// File: rtl/ixayoi_axi_rd_arb.sv
// rtl/ixayoi_axi_rd_arb.sv - round-robin arbiter of an instruction burst port and a data single-beat port onto one AXI4 read master
// One transaction outstanding at a time; R beats are routed back to whichever port won the grant.
module ixayoi_axi_rd_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic [7:0]        i_arlen,
  input  logic [1:0]        i_arburst,
  input  logic              i_arvalid,
  output logic              i_arready,
  output logic [DATA_W-1:0] i_rdata,
  output logic [1:0]        i_rresp,
  output logic              i_rlast,
  output logic              i_rvalid,
  input  logic              i_rready,
  input  logic [ADDR_W-1:0] d_araddr,
  input  logic              d_arvalid,
  output logic              d_arready,
  output logic [DATA_W-1:0] d_rdata,
  output logic [1:0]        d_rresp,
  output logic              d_rvalid,
  input  logic              d_rready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic              proto_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_d;
  logic              r_sel_d;
  logic              r_proto_err;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [7:0]        r_cnt;
  logic [1:0]        r_burst;
  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_beat;
  logic              w_cnt_zero;
  logic              w_sel_rready;

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    w_beat       = 1'b0;
    w_cnt_zero   = (r_cnt == 8'd0);
    w_sel_rready = r_sel_d ? d_rready : i_rready;
    i_arready    = 1'b0;
    d_arready    = 1'b0;
    m_arvalid    = 1'b0;
    m_rready     = 1'b0;
    i_rvalid     = 1'b0;
    d_rvalid     = 1'b0;
    case (r_state)
      IDLE: begin
        // d wins unless i is also asking and d was the last one served
        w_grant_d = d_arvalid && (!i_arvalid || !r_last_d);
        w_grant_i = i_arvalid && !w_grant_d;
        i_arready = w_grant_i;
        d_arready = w_grant_d;
        if (w_grant_i || w_grant_d) w_state_nxt = ADDR;
      end
      ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) w_state_nxt = DATA;
      end
      DATA: begin
        m_rready = w_sel_rready;
        i_rvalid = m_rvalid && !r_sel_d;
        d_rvalid = m_rvalid && r_sel_d;
        w_beat   = m_rvalid && w_sel_rready;
        if (w_beat && w_cnt_zero) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_last_d    <= 1'b0;
      r_sel_d     <= 1'b0;
      r_proto_err <= 1'b0;
      r_addr      <= '0;
      r_len       <= 8'd0;
      r_cnt       <= 8'd0;
      r_burst     <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_i || w_grant_d) begin
        r_sel_d <= w_grant_d;
        r_addr  <= w_grant_d ? d_araddr : i_araddr;
        r_len   <= w_grant_d ? 8'd0 : i_arlen;
        r_burst <= w_grant_d ? 2'b01 : i_arburst;
      end
      if (r_state == ADDR && m_arready) r_cnt <= r_len;
      // Completion is decided by our own count; a wrong rlast only raises the flag
      if (w_beat) begin
        if (m_rlast != w_cnt_zero) r_proto_err <= 1'b1;
        if (w_cnt_zero) r_last_d <= r_sel_d;
        else            r_cnt    <= r_cnt - 8'd1;
      end
    end
  end

  assign m_araddr  = r_addr;
  assign m_arlen   = r_len;
  assign m_arburst = r_burst;
  assign i_rdata   = m_rdata;
  assign i_rresp   = m_rresp;
  assign i_rlast   = m_rlast;
  assign d_rdata   = m_rdata;
  assign d_rresp   = m_rresp;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_ixayoi_axi_rd_arb.sv
// tb/tb_ixayoi_axi_rd_arb.sv - scoreboard bench for ixayoi_axi_rd_arb
// Requesters and a downstream slave model are driven on the falling edge and sampled 1ns later.
module tb_ixayoi_axi_rd_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_araddr;
  logic [7:0]  i_arlen;
  logic [1:0]  i_arburst;
  logic        i_arvalid, i_arready;
  logic [31:0] i_rdata;
  logic [1:0]  i_rresp;
  logic        i_rlast, i_rvalid, i_rready;
  logic [31:0] d_araddr;
  logic        d_arvalid, d_arready;
  logic [31:0] d_rdata;
  logic [1:0]  d_rresp;
  logic        d_rvalid, d_rready;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [1:0]  m_arburst;
  logic        m_arvalid, m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast, m_rvalid, m_rready;
  logic        proto_err;

  always #5 clk = ~clk;

  ixayoi_axi_rd_arb #(.ADDR_W(32), .DATA_W(32)) u_dut (
    .clk(clk), .reset(reset),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arburst(i_arburst),
    .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast),
    .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rresp(d_rresp), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .proto_err(proto_err)
  );

  typedef struct packed {logic [31:0] addr; logic [7:0] len; logic [1:0] burst;} ar_t;
  typedef struct packed {logic port_d; logic [31:0] data; logic [1:0] resp; logic last;} beat_t;

  ar_t         i_req_q[$];
  logic [31:0] d_req_q[$];
  logic        exp_grant_q[$];
  ar_t         exp_ar_q[$];
  beat_t       exp_beat_q[$];

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_grant_cyc = -100;
  int ar_delay = 0;
  int bad_beat = -1;
  int stall_cnt = 0;
  int s_wait = 0;
  logic        s_busy = 1'b0;
  logic [31:0] s_addr;
  logic [7:0]  s_len, s_beat;
  logic        act = 1'b0;
  logic        cur_d = 1'b0;
  logic        prev_stall = 1'b0;
  ar_t         prev_ar;
  logic        rand_bp = 1'b0;
  logic        chk_rst = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] sdata(input logic [31:0] a, input logic [7:0] b);
    return 32'hDEADBEEF ^ (a - 32'h1000) ^ {24'h0, b};
  endfunction

  function automatic logic [1:0] sresp(input logic [31:0] a, input logic [7:0] b);
    return a[7] ? b[1:0] : 2'b00;
  endfunction

  task automatic expect_txn(input logic is_d, input ar_t a);
    beat_t e;
    exp_grant_q.push_back(is_d);
    exp_ar_q.push_back(a);
    for (int b = 0; b <= int'(a.len); b++) begin
      e.port_d = is_d;
      e.data   = sdata(a.addr, b[7:0]);
      e.resp   = sresp(a.addr, b[7:0]);
      e.last   = (b == int'(a.len)) || (b == bad_beat);
      exp_beat_q.push_back(e);
    end
  endtask

  task automatic req_i(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    ar_t a;
    a.addr = addr; a.len = len; a.burst = burst;
    i_req_q.push_back(a);
  endtask

  task automatic exp_i(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    ar_t a;
    a.addr = addr; a.len = len; a.burst = burst;
    expect_txn(1'b0, a);
  endtask

  task automatic exp_d(input logic [31:0] addr);
    ar_t a;
    a.addr = addr; a.len = 8'd0; a.burst = 2'b01;
    expect_txn(1'b1, a);
  endtask

  task automatic drive();
    ar_t a;
    i_arvalid = (i_req_q.size() != 0);
    if (i_arvalid) begin
      a = i_req_q[0];
      i_araddr = a.addr; i_arlen = a.len; i_arburst = a.burst;
    end
    d_arvalid = (d_req_q.size() != 0);
    if (d_arvalid) d_araddr = d_req_q[0];
    i_rready  = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    d_rready  = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    m_arready = (s_wait >= ar_delay);
    m_rvalid  = s_busy && (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
    m_rdata   = s_busy ? sdata(s_addr, s_beat) : $urandom;
    m_rresp   = s_busy ? sresp(s_addr, s_beat) : 2'b00;
    m_rlast   = s_busy && ((s_beat == s_len) || (int'(s_beat) == bad_beat));
  endtask

  task automatic sample();
    beat_t e;
    ar_t   a;
    logic  g;
    logic [31:0] tmp;
    if (act) begin
      check("rvalid_route", {i_rvalid, d_rvalid}, cur_d ? {1'b0, m_rvalid} : {m_rvalid, 1'b0});
      check("rready_route", m_rready, cur_d ? d_rready : i_rready);
      if (m_rvalid && m_rready) begin
        if (exp_beat_q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          e = exp_beat_q.pop_front();
          check("beat_port", cur_d, e.port_d);
          check("beat_data", cur_d ? d_rdata : i_rdata, e.data);
          check("beat_resp", cur_d ? d_rresp : i_rresp, e.resp);
          if (!cur_d) check("i_rlast", i_rlast, e.last);
        end
        if (s_beat == s_len) begin s_busy = 1'b0; act = 1'b0; end
        else s_beat = s_beat + 8'd1;
      end
    end else begin
      check("r_quiet", {i_rvalid, d_rvalid, m_rready}, 3'b000);
    end
    if (i_arready || d_arready) begin
      if (exp_grant_q.size() == 0) check("unexpected_grant", {i_arready, d_arready}, 2'b00);
      else begin
        g = exp_grant_q.pop_front();
        check("grant_port", {i_arready, d_arready}, g ? 2'b01 : 2'b10);
      end
      check("grant_spacing", (cyc - last_grant_cyc) >= 3, 1);
      check("grant_has_valid", (i_arready && i_arvalid) || (d_arready && d_arvalid), 1);
      last_grant_cyc = cyc;
      cur_d = d_arready;
      if (i_arready && i_arvalid) a = i_req_q.pop_front();
      if (d_arready && d_arvalid) tmp = d_req_q.pop_front();
    end
    if (m_arvalid) begin
      check("ar_req_ready_low", {i_arready, d_arready}, 2'b00);
      if (prev_stall) check("ar_stable", {m_araddr, m_arlen, m_arburst}, prev_ar);
      if (m_arready) begin
        if (exp_ar_q.size() == 0) check("unexpected_ar", 1, 0);
        else begin
          a = exp_ar_q.pop_front();
          check("ar_fields", {m_araddr, m_arlen, m_arburst}, a);
        end
        s_busy = 1'b1; s_addr = m_araddr; s_len = m_arlen; s_beat = 8'd0;
        s_wait = 0; act = 1'b1;
      end else begin
        stall_cnt++;
        s_wait++;
      end
    end
    prev_stall = m_arvalid && !m_arready;
    prev_ar = {m_araddr, m_arlen, m_arburst};
  endtask

  task automatic tick();
    drive();
    #1;
    if (chk_rst) begin
      check("reset_outputs", {i_arready, d_arready, m_arvalid, m_rready, i_rvalid, d_rvalid, proto_err}, 7'd0);
      chk_rst = 1'b0;
    end
    if (reset) begin
      s_busy = 1'b0; s_wait = 0; act = 1'b0; prev_stall = 1'b0; last_grant_cyc = -100;
    end else begin
      sample();
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_req_q.delete(); d_req_q.delete();
    exp_grant_q.delete(); exp_ar_q.delete(); exp_beat_q.delete();
    tick();
    reset = 1'b0;
    chk_rst = 1'b1;
    tick();
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n = 0;
    while (((i_req_q.size() != 0) || (d_req_q.size() != 0) || (exp_beat_q.size() != 0) || act || s_busy)
           && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done"}, n < budget, 1);
    tick();
    tick();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    i_araddr = '0; i_arlen = '0; i_arburst = '0; d_araddr = '0;
    do_reset();

    // alternating grants with both requesters continuously valid
    rand_bp = 1'b1;
    d_req_q.push_back(32'h2000); d_req_q.push_back(32'h2004);
    req_i(32'h300, 8'd1, 2'b01); req_i(32'h400, 8'd2, 2'b10);
    exp_d(32'h2000); exp_i(32'h300, 8'd1, 2'b01);
    exp_d(32'h2004); exp_i(32'h400, 8'd2, 2'b10);
    run_until_idle("alternate", 400);
    rand_bp = 1'b0;

    d_req_q.push_back(32'h1000); exp_d(32'h1000);
    run_until_idle("d_single", 100);

    req_i(32'h80, 8'd3, 2'b01); exp_i(32'h80, 8'd3, 2'b01);
    run_until_idle("i_burst4", 100);
    check("proto_err_clean", proto_err, 1'b0);

    ar_delay = 5; stall_cnt = 0;
    d_req_q.push_back(32'h3000); exp_d(32'h3000);
    run_until_idle("ar_stall", 100);
    check("ar_stall_cycles", stall_cnt, 5);
    ar_delay = 0;

    bad_beat = 0;
    req_i(32'h500, 8'd1, 2'b01); exp_i(32'h500, 8'd1, 2'b01);
    run_until_idle("bad_rlast", 100);
    bad_beat = -1;
    check("proto_err_set", proto_err, 1'b1);
    d_req_q.push_back(32'h1040); exp_d(32'h1040);
    run_until_idle("after_err", 100);
    check("proto_err_sticky", proto_err, 1'b1);

    req_i(32'h600, 8'd3, 2'b01); exp_i(32'h600, 8'd3, 2'b01);
    n = 0;
    while (!(s_busy && s_beat == 8'd2) && n < 100) begin tick(); n++; end
    check("reach_beat2", n < 100, 1);
    do_reset();
    d_req_q.push_back(32'h1080); req_i(32'h700, 8'd0, 2'b00);
    exp_d(32'h1080); exp_i(32'h700, 8'd0, 2'b00);
    run_until_idle("post_reset", 100);
    check("proto_err_after_reset", proto_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/ixayoi_axi_rd_arb.md
IXAYOI_AXI_RD_ARB -- requirements
Module: ixayoi_axi_rd_arb

Interface
REQ-001 Parameter: ADDR_W, 32, address width of all AR channels.
REQ-002 Parameter: DATA_W, 32, data width of all R channels.
REQ-003 The block SHALL have the following ports. The clock is clk. The reset is reset: one clock, synchronous, active-high.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 i_araddr/i_arlen/i_arburst  in  ADDR_W/8/2  instruction-side burst read request.
REQ-007 i_arvalid  in  1; i_arready  out  1  instruction AR handshake.
REQ-008 i_rdata/i_rresp/i_rlast  out  DATA_W/2/1; i_rvalid  out  1; i_rready  in  1  instruction R channel.
REQ-009 d_araddr  in  ADDR_W; d_arvalid  in  1; d_arready  out  1  data-side single-beat (AXI4-Lite) request.
REQ-010 d_rdata/d_rresp  out  DATA_W/2; d_rvalid  out  1; d_rready  in  1  data R channel.
REQ-011 m_araddr/m_arlen/m_arburst  out  ADDR_W/8/2; m_arvalid  out  1; m_arready  in  1  shared AXI4 master AR.
REQ-012 m_rdata/m_rresp/m_rlast  in  DATA_W/2/1; m_rvalid  in  1; m_rready  out  1  shared master R.
REQ-013 proto_err  out  1  sticky flag: downstream rlast mismatched the expected beat count.

Function
REQ-014 FSM states SHALL be IDLE, ADDR, DATA; exactly one transaction outstanding on m at any time.
REQ-015 In IDLE, with only one of i_arvalid/d_arvalid high, that requester SHALL be granted.
REQ-016 In IDLE, with both high, the requester not granted last SHALL win (round-robin); after reset, d wins first.
REQ-017 On grant, the arbiter SHALL assert the winner's arready for exactly that one cycle, latch addr/len/burst into registers, and move to ADDR; the loser's arready SHALL stay low.
REQ-018 A d grant SHALL latch arlen=0 and arburst=2'b01 (INCR); an i grant SHALL latch the requester's i_arlen/i_arburst unchanged.
REQ-019 i_arready and d_arready SHALL be low outside the IDLE grant cycle.
REQ-020 In ADDR, m_arvalid SHALL be 1 with the latched values held stable until m_arready; on that handshake, go to DATA and load beat counter = latched arlen.
REQ-021 In DATA, m_rdata/m_rresp/m_rvalid SHALL route combinationally to the granted port only (other port's rvalid=0). m_rready SHALL equal the granted port's rready. i_rlast SHALL equal m_rlast.
REQ-022 Each m_rvalid&&m_rready beat SHALL decrement the beat counter.
REQ-023 The beat with counter==0 SHALL end the transaction: return to IDLE next cycle, and record last-grant.
REQ-024 If m_rlast disagrees with counter==0 on any beat, the arbiter SHALL set proto_err. The transaction SHALL still end only on counter==0.
REQ-025 No same-cycle turnaround: a new grant SHALL occur no earlier than the cycle after DATA completes, so minimum issue spacing is 3 cycles.
REQ-026 Non-OKAY rresp SHALL pass through unchanged and SHALL NOT alter sequencing.

Reset
REQ-027 On reset: state=IDLE, last-grant=i, counter=0, proto_err=0, all arready/arvalid/rvalid/rready outputs 0.
REQ-028 Reset mid-transaction SHALL abandon it with no further handshakes; the downstream is reset by the same signal.

Verification
REQ-029 d_arvalid only, d_araddr=0x1000 -> d_arready one cycle; m_araddr=0x1000, arlen=0, arburst=01; one beat 0xDEADBEEF reaches d_rdata; back in IDLE.
REQ-030 i_arvalid only, arlen=3, addr=0x80 -> 4 beats routed to i; i_rlast on 4th; counter ends at 0; proto_err=0.
REQ-031 Both valid continuously from reset -> grants alternate d,i,d,i; neither port receives the other's rvalid.
REQ-032 m_arready held low 5 cycles in ADDR -> m_arvalid and m_araddr stable all 5 cycles; i/d arready stay 0.
REQ-033 i burst arlen=1, m_rlast asserted on beat 0 -> proto_err=1 and stays 1; transaction ends after beat 1.
REQ-034 reset pulsed during DATA beat 2 of 4 -> next cycle all outputs at REQ-027 values; fresh d request is granted first.
